// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch-stage controller
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Encoding of the no-op instruction placed in IF/ID after reset.
    localparam int unsigned NOP_ENC = 0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-high reset
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage controller: PC, imem request, skid buffer and IF/ID register
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               PC_W     = 16,
    parameter int               INSTR_W  = 16,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_freeze,
    input  logic               resolved,
    input  logic               do_flush,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               hz_err
);

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_ENC);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic                fetch_go;

    logic [PC_W-1:0]     pc_reg;
    logic                req_q;
    logic [PC_W-1:0]     req_pc_q;

    logic                skid_valid;
    logic [PC_W-1:0]     skid_pc;
    logic [INSTR_W-1:0]  skid_instr;

    // The transition target depends only on the hazard inputs; the current
    // state only decides whether this cycle may issue a request.
    always_comb begin
        state_d  = state_q;
        fetch_go = 1'b0;
        if (do_flush) begin
            state_d = ST_FLUSH;
        end else if (pc_freeze) begin
            state_d = ST_STALL;
        end else begin
            state_d  = ST_RUN;
            fetch_go = (state_q == ST_RUN);
        end
    end

    assign imem_req  = fetch_go & ~rst;
    assign imem_addr = pc_reg;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_reg     <= RESET_PC;
            req_q      <= 1'b0;
            req_pc_q   <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP;
        end else begin
            state_q <= state_d;
            if (do_flush) begin
                // Redirect: anything fetched before the flush is squashed.
                pc_reg     <= redirect_pc;
                req_q      <= 1'b0;
                skid_valid <= 1'b0;
                ifid_valid <= 1'b0;
            end else if (pc_freeze) begin
                req_q <= 1'b0;
                if (req_q) begin
                    skid_valid <= 1'b1;
                    skid_pc    <= req_pc_q;
                    skid_instr <= imem_rdata;
                end
            end else begin
                req_q <= fetch_go;
                if (fetch_go) begin
                    pc_reg   <= pc_reg + PC_W'(1);
                    req_pc_q <= pc_reg;
                end
                // A parked word drains first; no request was in flight then.
                if (skid_valid && (state_q == ST_RUN)) begin
                    ifid_valid <= 1'b1;
                    ifid_pc    <= skid_pc;
                    ifid_instr <= skid_instr;
                    skid_valid <= 1'b0;
                end else if (req_q) begin
                    ifid_valid <= 1'b1;
                    ifid_pc    <= req_pc_q;
                    ifid_instr <= imem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hz_err <= 1'b0;
        end else if (resolved == pc_freeze) begin
            hz_err <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state_q == ST_STALL),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed table-driven bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        pc_freeze;
    logic        resolved;
    logic        do_flush;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        ifid_valid;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_instr;
    logic [1:0]  state;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;
    logic        hz_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .PC_W     (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_freeze   (pc_freeze),
        .resolved    (resolved),
        .do_flush    (do_flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .hz_err      (hz_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: word at address a reads as a + 0x100, one cycle later.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr + 16'h0100) : 16'hDEAD;
    end

    typedef struct {
        logic        rst, frz, res, fl;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ipc, ins;
        logic [1:0]  st;
        logic [3:0]  sc, fc;
        logic        he;
    } vec_t;

    vec_t vt[$];

    function automatic void av(logic r, logic f, logic s, logic fl, logic [15:0] rpc,
                               logic req, logic [15:0] addr, logic vld,
                               logic [15:0] ipc, logic [15:0] ins, logic [1:0] st,
                               logic [3:0] sc, logic [3:0] fc, logic he);
        vt.push_back('{r, f, s, fl, rpc, req, addr, vld, ipc, ins, st, sc, fc, he});
    endfunction

    task automatic chk(string tag, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic req, logic [15:0] addr, logic vld,
                             logic chk_data, logic [15:0] ipc, logic [15:0] ins,
                             logic [1:0] st, logic [3:0] sc, logic [3:0] fc, logic he);
        chk(tag, "imem_req", {31'd0, imem_req}, {31'd0, req});
        chk(tag, "imem_addr", {16'd0, imem_addr}, {16'd0, addr});
        chk(tag, "ifid_valid", {31'd0, ifid_valid}, {31'd0, vld});
        if (chk_data) begin
            chk(tag, "ifid_pc", {16'd0, ifid_pc}, {16'd0, ipc});
            chk(tag, "ifid_instr", {16'd0, ifid_instr}, {16'd0, ins});
        end
        chk(tag, "state", {30'd0, state}, {30'd0, st});
        chk(tag, "stall_cnt", {28'd0, stall_cnt}, {28'd0, sc});
        chk(tag, "flush_cnt", {28'd0, flush_cnt}, {28'd0, fc});
        chk(tag, "hz_err", {31'd0, hz_err}, {31'd0, he});
    endtask

    task automatic drive(logic r, logic f, logic s, logic fl, logic [15:0] rpc);
        @(negedge clk);
        rst         = r;
        pc_freeze   = f;
        resolved    = s;
        do_flush    = fl;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_freeze = 1'b0; resolved = 1'b1; do_flush = 1'b0;
        redirect_pc = 16'h0000;
        @(negedge clk);
        @(negedge clk);

        //  rst frz res fl  rpc      req addr     vld ipc      ins      st sc fc he
        av(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h0100, 0, 0, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0003, 1, 16'h0001, 16'h0101, 0, 0, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002, 16'h0102, 0, 0, 0, 0);
        // freeze three cycles at PC=5
        av(0, 1, 0, 0, 16'h0000, 0, 16'h0005, 1, 16'h0003, 16'h0103, 0, 0, 0, 0);
        av(0, 1, 0, 0, 16'h0000, 0, 16'h0005, 1, 16'h0003, 16'h0103, 1, 0, 0, 0);
        av(0, 1, 0, 0, 16'h0000, 0, 16'h0005, 1, 16'h0003, 16'h0103, 1, 1, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 0, 16'h0005, 1, 16'h0003, 16'h0103, 1, 2, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0005, 1, 16'h0003, 16'h0103, 0, 3, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004, 16'h0104, 0, 3, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0007, 1, 16'h0005, 16'h0105, 0, 3, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0008, 1, 16'h0006, 16'h0106, 0, 3, 0, 0);
        // flush at PC=9 to 0x40
        av(0, 0, 1, 1, 16'h0040, 0, 16'h0009, 1, 16'h0007, 16'h0107, 0, 3, 0, 0);
        av(0, 0, 1, 0, 16'h0000, 0, 16'h0040, 0, 16'h0000, 16'h0000, 2, 3, 1, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0, 3, 1, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000, 16'h0000, 0, 3, 1, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0042, 1, 16'h0040, 16'h0140, 0, 3, 1, 0);
        // flush with freeze held, target 0x80
        av(0, 1, 0, 1, 16'h0080, 0, 16'h0043, 1, 16'h0041, 16'h0141, 0, 3, 1, 0);
        av(0, 1, 0, 0, 16'h0000, 0, 16'h0080, 0, 16'h0000, 16'h0000, 2, 3, 2, 0);
        av(0, 1, 0, 0, 16'h0000, 0, 16'h0080, 0, 16'h0000, 16'h0000, 1, 3, 2, 0);
        av(0, 0, 1, 0, 16'h0000, 0, 16'h0080, 0, 16'h0000, 16'h0000, 1, 4, 2, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0000, 0, 5, 2, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0081, 0, 16'h0000, 16'h0000, 0, 5, 2, 0);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0082, 1, 16'h0080, 16'h0180, 0, 5, 2, 0);
        // inconsistent hazard inputs for one freeze cycle
        av(0, 1, 1, 0, 16'h0000, 0, 16'h0083, 1, 16'h0081, 16'h0181, 0, 5, 2, 0);
        av(0, 0, 1, 0, 16'h0000, 0, 16'h0083, 1, 16'h0081, 16'h0181, 1, 5, 2, 1);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0083, 1, 16'h0081, 16'h0181, 0, 6, 2, 1);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0084, 1, 16'h0082, 16'h0182, 0, 6, 2, 1);
        av(0, 0, 1, 0, 16'h0000, 1, 16'h0085, 1, 16'h0083, 16'h0183, 0, 6, 2, 1);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].frz, vt[i].res, vt[i].fl, vt[i].rpc);
            check_all($sformatf("row%0d", i), vt[i].req, vt[i].addr, vt[i].vld,
                      vt[i].vld | vt[i].rst, vt[i].ipc, vt[i].ins, vt[i].st,
                      vt[i].sc, vt[i].fc, vt[i].he);
        end

        // Long freeze: counter saturates; in-flight word for PC 0x85 parks in skid.
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 16'h0000);
        drive(0, 1, 0, 0, 16'h0000);
        check_all("sat", 0, 16'h0086, 1, 1, 16'h0084, 16'h0184, 1, 4'hF, 2, 1);

        // Reset mid-stall.
        drive(1, 1, 0, 0, 16'h0000);
        chk("rst_in", "imem_req", {31'd0, imem_req}, 32'd0);
        drive(1, 1, 0, 0, 16'h0000);
        check_all("rst", 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 16'h0000);
        check_all("post0", 1, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 16'h0000);
        check_all("post1", 1, 16'h0001, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 16'h0000);
        check_all("post2", 1, 16'h0002, 1, 1, 16'h0000, 16'h0100, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller sitting directly downstream of the hazard unit: consumes its registered `pc_freeze`, `resolved` and `do_flush` outputs and drives the program counter, the instruction-memory request and the IF/ID pipeline register. It holds fetch on a freeze, redirects and squashes on a flush, and parks any in-flight instruction in a one-entry skid buffer so no fetched word is lost across a stall. It also keeps saturating stall and flush event counters for bring-up visibility.

## Interface
- `PC_W`, 16, PC / instruction-memory word-address width
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 0, PC value after reset
- `CNT_W`, 16, width of the stall and flush counters

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `pc_freeze` in 1: hold fetch (from hazard unit, registered)
- `resolved` in 1: no hazard pending (from hazard unit; nominally `!pc_freeze`)
- `do_flush` in 1: one-cycle squash/redirect pulse (from hazard unit)
- `redirect_pc` in PC_W: target PC, sampled when `do_flush`=1
- `imem_req` out 1: fetch request this cycle
- `imem_addr` out PC_W: fetch word address (= PC register)
- `imem_rdata` in INSTR_W: data for the request issued the previous cycle
- `ifid_valid` out 1: IF/ID holds a live instruction
- `ifid_pc` out PC_W: PC of IF/ID instruction
- `ifid_instr` out INSTR_W: IF/ID instruction
- `state` out 2: current FSM state, for debug
- `stall_cnt` out CNT_W: cycles spent in STALL, saturating
- `flush_cnt` out CNT_W: `do_flush` pulses seen, saturating
- `hz_err` out 1: sticky; set when `resolved == pc_freeze`

## Operation
- FSM states RUN, STALL, FLUSH; reset state RUN.
- Priority every cycle: `do_flush` > `pc_freeze` > normal fetch.
- RUN, no hazard: `imem_req`=1, `imem_addr`=PC; PC <= PC+1 (mod 2^PC_W). Registered `req_q`/`pc_q` track the in-flight request.
- Response capture: when `req_q`=1 and not killed, the cycle's `imem_rdata` loads IF/ID {`pc_q`, data}, `ifid_valid`=1; if STALL is entered that cycle, it loads the skid buffer instead, IF/ID holds.
- `pc_freeze`=1, `do_flush`=0 (from RUN or FLUSH): `imem_req`=0, PC and IF/ID hold; go STALL.
- STALL: `imem_req`=0, all hold; `stall_cnt`++ each STALL cycle. Exit to RUN when `pc_freeze`=0.
- First RUN cycle after STALL: if skid valid, IF/ID <= skid, skid cleared, and a new request issues at PC in the same cycle.
- `do_flush`=1 in any state: PC <= `redirect_pc`; `ifid_valid` <= 0; skid cleared; response arriving this cycle discarded; `imem_req`=0; `flush_cnt`++; go FLUSH.
- FLUSH (one cycle, no request): next state STALL if `pc_freeze`=1, else RUN; a new `do_flush` re-enters FLUSH with the new target.
- `hz_err` set on any cycle with `resolved == pc_freeze`; `pc_freeze` is authoritative. Cleared only by reset.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset: PC=`RESET_PC`, `imem_req`=0 during reset; `ifid_valid`=0, `ifid_pc`=0, `ifid_instr`=0 (NOP), skid empty, `req_q`=0, counters 0, `hz_err`=0, `state`=RUN.
- First cycle after reset: `imem_req`=1, `imem_addr`=`RESET_PC`.
- `imem_addr`, `imem_req` combinational from state/PC and current hazard inputs.
- Fetch-to-IF/ID latency: 2 edges (request at t, data at t+1, IF/ID valid at t+2).
- Flush at t: redirect request issued at t+2, redirect instruction valid in IF/ID at t+4.
- Reset mid-stall or mid-flush: all state to reset values in the same edge; in-flight data dropped.

## Structure
- `fetch_pkg`: state enum (RUN/STALL/FLUSH), `NOP` instruction constant.
- Sub-module `sat_counter` (parameter width, `clk`, `rst`, `inc`, `count`), instantiated twice.
- FSM, PC, skid and IF/ID registers in `fetch_ctrl`.

## Test plan
- Reset then free run, `imem_rdata`=addr+0x100 -> `imem_addr` 0,1,2…; IF/ID valid from cycle 3 with pc 0/instr 0x100, increment per cycle.
- `pc_freeze`=1 three cycles after running to PC=5 -> `imem_req`=0, IF/ID holds pc 3, skid holds pc 4; on release IF/ID pc 4 then pc 5, no drop or duplicate; `stall_cnt`=3.
- `do_flush`=1 with `redirect_pc`=0x40 at PC=9 -> `ifid_valid`=0 next cycle, in-flight word dropped, `imem_addr`=0x40 two cycles later, `flush_cnt`=1.
- `do_flush` together with `pc_freeze` held two more cycles -> FLUSH then STALL; first request at redirect target after freeze drops.
- `resolved`=1 with `pc_freeze`=1 one cycle -> `hz_err`=1 sticky, stall behaviour unaffected.
- CNT_W=4, 20-cycle freeze -> `stall_cnt` saturates at 15; `rst` pulse mid-stall -> all outputs to reset values.
